water_reminder_ctrl: RTL
========================

# water_reminder_ctrl

Sequencing controller for the water-tracking datapath. It generates the periodic sample strobe that paces the `waterDrunk` tracker and watches that tracker's cumulative `water_Drunk` count over fixed intervals. It raises a reminder when too little water was drunk in an interval and latches a goal-reached flag once the daily total is met. It sits between the level sensor/`waterDrunk` pair and the user-facing LED/buzzer/button logic.

## Interface
Parameters:
- TICKS_PER_SAMPLE, 4: clock cycles per sample strobe; must be ≥2.
- SAMPLES_PER_INTERVAL, 8: sample strobes per evaluation interval; must be ≥1.
- MIN_SIP, 2: minimum `water_Drunk` increase per interval before a reminder fires; 6-bit.
- GOAL, 40: `water_Drunk` value that completes the goal; 6-bit, must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- water_Drunk  in  6  cumulative drunk count from the `waterDrunk` block.
- ack  in  1  user acknowledge, sampled each edge.
- sample_en  out  1  one-cycle strobe telling `waterDrunk` to sample `water_level`.
- remind  out  1  reminder active (drives LED/buzzer).
- goal_met  out  1  daily goal reached.
- miss_count  out  4  number of reminders issued, saturating.

## Operation
- States: MONITOR, REMIND, DONE. Reset state is MONITOR.
- tick_cnt cycles 0..TICKS_PER_SAMPLE-1 and wraps to 0. It runs in all states.
- sample_en = (tick_cnt == TICKS_PER_SAMPLE-1). It is decoded from the register, so it is glitch-free and high for exactly one cycle per period in every state.
- intv_cnt is 0..SAMPLES_PER_INTERVAL-1. It increments on edges where sample_en=1.
- baseline is a 6-bit register holding `water_Drunk` at the start of the interval.
- delta = water_Drunk − baseline, computed modulo 64 (6-bit unsigned wrap).
- The interval end is an edge with sample_en=1 and intv_cnt==SAMPLES_PER_INTERVAL-1. On that edge, in MONITOR or REMIND:
  - if delta < MIN_SIP: go to or stay in REMIND, and increment miss_count (saturating at 15).
  - otherwise: go to MONITOR.
  - in both cases: baseline←water_Drunk and intv_cnt←0.
- In REMIND, on any edge:
  - ack=1 → MONITOR; baseline←water_Drunk; intv_cnt←0; tick_cnt is not disturbed.
  - else if delta ≥ MIN_SIP → MONITOR; baseline and intv_cnt are unchanged.
- ack in MONITOR or DONE has no effect.
- Priority on one edge, highest first: reset > goal (water_Drunk ≥ GOAL → DONE) > ack > interval-end evaluation > auto-clear.
  - Consequence: ack coinciding with an interval end does not increment miss_count, and the next interval restarts from 0.
- DONE is terminal until reset: remind=0, goal_met=1, and counters freeze except tick_cnt and sample_en. DONE holds even if water_Drunk later drops below GOAL.
- remind = (state==REMIND); goal_met = (state==DONE). Both are decoded from the state register.

## Timing
- Reset values: state MONITOR, tick_cnt 0, intv_cnt 0, baseline 0, miss_count 0. All outputs are 0 during reset and in the first cycle after reset.
- Edge 1 is the first rising edge with reset low.
  - sample_en is first high after edge TICKS_PER_SAMPLE-1, then every TICKS_PER_SAMPLE cycles.
  - The first interval-end edge is TICKS_PER_SAMPLE×SAMPLES_PER_INTERVAL (32 with defaults).
- All input reactions (ack, goal, delta) have 1-cycle latency: the input is sampled at edge N and the output changes after edge N.
- Reset asserted mid-REMIND or mid-DONE clears everything at the next edge; no output holds past that edge.
- water_Drunk is used unregistered. It must be stable at each rising edge, which is true because it comes from same-clock `waterDrunk`.

## Test plan
All scenarios use default parameters.
1. Reset, hold water_Drunk=0 → sample_en high after edges 3, 7, 11, …; remind rises after edge 32; miss_count=1; after edge 64, miss_count=2 and remind stays 1.
2. Raise water_Drunk 0→3 at edge 20 → no remind at edge 32; baseline=3; hold at 3 → remind after edge 64.
3. Remind active, pulse ack for 1 cycle at edge 40 → remind=0 after edge 40; next evaluation at edge 72 (8 sample strobes later), not edge 64.
4. Remind active with baseline=5, set water_Drunk=7 → remind clears after the next edge with no ack; miss_count unchanged.
5. Set water_Drunk=40 while remind=1 → goal_met=1 and remind=0 after the next edge. Then drop water_Drunk to 0 and pulse ack → still DONE. Assert reset → all outputs 0 after that edge.
6. Hold water_Drunk=0 for 17 intervals, pulsing ack once mid-interval → miss_count saturates at 15. Also assert ack exactly on an interval-end edge → remind=0 after it and miss_count is not incremented.

Source files
------------

// File: rtl/water_reminder_ctrl.sv
// Sequencing controller for the water tracker: paces sampling, evaluates intake per
// interval, raises a reminder on low intake and latches goal completion.
module water_reminder_ctrl #(
    parameter int unsigned TICKS_PER_SAMPLE     = 4,
    parameter int unsigned SAMPLES_PER_INTERVAL = 8,
    parameter int unsigned MIN_SIP              = 2,
    parameter int unsigned GOAL                 = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] water_Drunk,
    input  logic       ack,
    output logic       sample_en,
    output logic       remind,
    output logic       goal_met,
    output logic [3:0] miss_count
);

    localparam int unsigned TW = $clog2(TICKS_PER_SAMPLE);
    localparam int unsigned IW = (SAMPLES_PER_INTERVAL > 1) ? $clog2(SAMPLES_PER_INTERVAL) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SAMPLE - 1);
    localparam logic [IW-1:0] INTV_LAST  = IW'(SAMPLES_PER_INTERVAL - 1);
    localparam logic [5:0]    MIN_SIP_V  = 6'(MIN_SIP);
    localparam logic [5:0]    GOAL_V     = 6'(GOAL);

    typedef enum logic [1:0] {
        MONITOR,
        REMIND,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [IW-1:0] intv_cnt, intv_nxt;
    logic [5:0]    baseline, base_nxt;
    logic [3:0]    miss_nxt;

    logic [5:0] delta;
    logic       goal_hit;
    logic       interval_end;

    // Intake since the interval began; the drunk count is free to wrap at 64.
    assign delta        = water_Drunk - baseline;
    assign goal_hit     = (water_Drunk >= GOAL_V);
    assign sample_en    = (tick_cnt == TICK_LAST);
    assign interval_end = sample_en && (intv_cnt == INTV_LAST);
    assign remind       = (state == REMIND);
    assign goal_met     = (state == DONE);

    assign tick_nxt = sample_en ? '0 : tick_cnt + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
        state_nxt = state;
        intv_nxt  = intv_cnt;
        base_nxt  = baseline;
        miss_nxt  = miss_count;
        case (state)
            MONITOR, REMIND: begin
                if (goal_hit) begin
                    state_nxt = DONE;
                end else if (state == REMIND && ack) begin
                    state_nxt = MONITOR;
                    base_nxt  = water_Drunk;
                    intv_nxt  = '0;
                end else if (interval_end) begin
                    if (delta < MIN_SIP_V) begin
                        state_nxt = REMIND;
                        if (miss_count != 4'hF) miss_nxt = miss_count + 4'd1;
                    end else begin
                        state_nxt = MONITOR;
                    end
                    base_nxt = water_Drunk;
                    intv_nxt = '0;
                end else begin
                    if (sample_en) intv_nxt = intv_cnt + 1'b1;
                    if (state == REMIND && delta >= MIN_SIP_V) state_nxt = MONITOR;
                end
            end
            default: ;  // DONE is terminal until reset; only the tick counter keeps running
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= MONITOR;
            tick_cnt   <= '0;
            intv_cnt   <= '0;
            baseline   <= '0;
            miss_count <= '0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            intv_cnt   <= intv_nxt;
            baseline   <= base_nxt;
            miss_count <= miss_nxt;
        end
    end

endmodule
